spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Three-requester arbiter in front of a single SPI master: grants, sequences one transfer, enforces a CS gap.
// Build option: define SPI_ARBITER_FIXED_PRIO_EN for fixed priority (0 highest); default is round-robin.
module spi_arbiter #(
  parameter int XFER_CYCLES = 9,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [5:0]  req_ss,
  input  logic [23:0] req_data,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        m_start,
  output logic [1:0]  m_slave_select,
  output logic [7:0]  m_data_to_send,
  input  logic [7:0]  m_data_received
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'((XFER_CYCLES > 0) ? XFER_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Slave select 3 addresses no device: the slot is consumed without strobing the master.
  localparam logic [1:0] SS_NULL = 2'b11;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             win_valid;
  logic [1:0]       win_idx;
  logic [1:0]       win_ss;
  logic [7:0]       win_data;

`ifdef SPI_ARBITER_FIXED_PRIO_EN
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win_valid = |req;
    win_idx   = 2'd2;
    if (req[0])      win_idx = 2'd0;
    else if (req[1]) win_idx = 2'd1;
  end
`else
  logic [1:0] rr_ptr;
  logic [1:0] prio_1;
  logic [1:0] prio_2;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign prio_1 = next_idx(rr_ptr);
  assign prio_2 = next_idx(prio_1);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win_valid = |req;
    win_idx   = prio_2;
    if (req[rr_ptr])      win_idx = rr_ptr;
    else if (req[prio_1]) win_idx = prio_1;
  end

  // The pointer moves past the requester just served; one-hot gnt maps straight onto the next index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (state == ST_DONE) begin
      rr_ptr <= {gnt[1], gnt[0]};
    end
  end
`endif

  assign win_ss   = req_ss[{win_idx, 1'b0} +: 2];
  assign win_data = req_data[{win_idx, 3'b000} +: 8];
  assign busy     = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      gnt            <= '0;
      done           <= '0;
      rx_data        <= '0;
      m_start        <= 1'b0;
      m_slave_select <= SS_NULL;
      m_data_to_send <= '0;
    end else begin
      done    <= '0;
      m_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt            <= 3'b001 << win_idx;
            m_slave_select <= win_ss;
            m_data_to_send <= win_data;
            m_start        <= (win_ss != SS_NULL);
            state          <= ST_START;
          end
        end
        ST_START: begin
          cnt <= '0;
          if (m_slave_select == SS_NULL) begin
            done    <= gnt;
            rx_data <= 8'hFF;
            state   <= ST_DONE;
          end else begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (cnt == XFER_LAST) begin
            done    <= gnt;
            rx_data <= m_data_received;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          gnt   <= '0;
          cnt   <= '0;
          state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus random traffic, scored against a transfer-level model.
module tb_spi_arbiter;

  localparam int XFER_CYCLES = 9;
  localparam int GAP_CYCLES  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic [5:0]  req_ss = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rx_data;
  logic        busy;
  logic        m_start;
  logic [1:0]  m_slave_select;
  logic [7:0]  m_data_to_send;
  logic [7:0]  m_data_received = '0;

  spi_arbiter #(.XFER_CYCLES(XFER_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ss(req_ss), .req_data(req_data),
    .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy), .m_start(m_start),
    .m_slave_select(m_slave_select), .m_data_to_send(m_data_to_send),
    .m_data_received(m_data_received)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One expected transfer: who, what was latched, what comes back, and when.
  typedef struct {
    int         idx;
    logic [1:0] ss;
    logic [7:0] data;
    logic [7:0] rx;
    int         grant_cyc;
    int         done_cyc;
  } xfer_t;

  xfer_t      sb[$];
  int         cyc = 0;
  int         last_gnt = 2;
  int         last_done_cyc = -1000;
  logic [2:0] prev_gnt = '0;

  function automatic int model_winner(input logic [2:0] r, input int last);
`ifdef SPI_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`endif
    return -1;
  endfunction

  function automatic int done_index(input logic [2:0] d);
    return d[0] ? 0 : (d[1] ? 1 : 2);
  endfunction

  // Monitor: predicts at each new grant, pops and compares at each done pulse.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      sb.delete();
      last_gnt      = 2;
      last_done_cyc = -1000;
      prev_gnt      = '0;
    end else begin
      if (gnt != 3'b000 && prev_gnt == 3'b000) begin
        int    w;
        xfer_t t;
        w = model_winner(req, last_gnt);
        if (w < 0) begin
          check("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          t.idx       = w;
          t.ss        = req_ss[2*w +: 2];
          t.data      = req_data[8*w +: 8];
          t.rx        = (t.ss == 2'b11) ? 8'hFF : m_data_received;
          t.grant_cyc = cyc;
          t.done_cyc  = cyc + ((t.ss == 2'b11) ? 1 : XFER_CYCLES + 1);
          check("grant_winner", 32'(gnt), 32'(3'b001 << w));
          check("grant_gap_ok", 32'(cyc - last_done_cyc - 1 >= GAP_CYCLES), 32'd1);
          check("m_start_at_grant", 32'(m_start), 32'(t.ss != 2'b11));
          sb.push_back(t);
        end
      end
      if (sb.size() > 0) begin
        check("ss_stable", 32'(m_slave_select), 32'(sb[0].ss));
        check("data_stable", 32'(m_data_to_send), 32'(sb[0].data));
        if (cyc == sb[0].grant_cyc + 1) check("m_start_one_cycle", 32'(m_start), 32'd0);
      end
      if (done != 3'b000) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          xfer_t t;
          t = sb.pop_front();
          check("done_vector", 32'(done), 32'(3'b001 << t.idx));
          check("done_latency", 32'(cyc - t.grant_cyc), 32'(t.done_cyc - t.grant_cyc));
          check("rx_data", 32'(rx_data), 32'(t.rx));
          last_gnt      = t.idx;
          last_done_cyc = cyc;
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        check("done_missing", 32'(cyc - sb[0].grant_cyc), 32'(sb[0].done_cyc - sb[0].grant_cyc));
        void'(sb.pop_front());
      end
      if (cyc == last_done_cyc + 1) check("gnt_clear_after_done", 32'(gnt), 32'd0);
      prev_gnt = gnt;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rx"}, 32'(rx_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_m_start"}, 32'(m_start), 32'd0);
    check({tag, "_ss"}, 32'(m_slave_select), 32'd3);
    check({tag, "_data"}, 32'(m_data_to_send), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start_at, done_at, saw_start, k;
    int order[4];

    #1 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single transfer, then a data change while the transfer runs.
    @(negedge clk);
    req_ss[1:0]     = 2'd0;
    req_data[7:0]   = 8'hA5;
    m_data_received = 8'h3C;
    req             = 3'b001;
    start_at = -1;
    done_at  = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(negedge clk);
      if (m_start && start_at < 0) start_at = n;
      if (n == 5) req_data[7:0] = 8'h5A;
      if (done[0]) begin
        done_at = n;
        check("single_data_held", 32'(m_data_to_send), 32'hA5);
        req = 3'b000;
      end
    end
    req = 3'b000;
    check("single_m_start_latency", 32'(start_at), 32'd1);
    check("single_done_latency", 32'(done_at), 32'(XFER_CYCLES + 2));
    check("single_rx", 32'(rx_data), 32'h3C);
    wait_idle(20);

    // Null slave: no strobe, immediate completion with all-ones data.
    @(negedge clk);
    req_ss[5:4]     = 2'b11;
    req_data[23:16] = 8'h77;
    req             = 3'b100;
    saw_start = 0;
    done_at   = -1;
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(negedge clk);
      if (m_start) saw_start = 1;
      if (done[2]) begin
        done_at = n;
        req = 3'b000;
      end
    end
    req = 3'b000;
    check("null_no_m_start", 32'(saw_start), 32'd0);
    check("null_done_latency", 32'(done_at), 32'd2);
    check("null_rx", 32'(rx_data), 32'hFF);
    wait_idle(20);

    // Reset in the fourth XFER cycle, then the held request is served afresh.
    @(negedge clk);
    req_ss[3:2]    = 2'd1;
    req_data[15:8] = 8'hC3;
    req            = 3'b010;
    k = 0;
    while (!m_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("reset_test_m_start_seen", 32'(m_start), 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    check("reset_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    start_at = -1;
    done_at  = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(negedge clk);
      if (m_start && start_at < 0) start_at = n;
      if (done[1]) begin
        done_at = n;
        req = 3'b000;
      end
    end
    req = 3'b000;
    check("post_reset_m_start_latency", 32'(start_at), 32'd1);
    check("post_reset_done_latency", 32'(done_at), 32'(XFER_CYCLES + 2));
    wait_idle(20);

    // Contention with all three requests held.
    pulse_reset();
    req_ss   = 6'b10_01_00;
    req_data = 24'h33_22_11;
    req      = 3'b111;
    k = 0;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        order[k] = done_index(done);
        k++;
      end
    end
    req = 3'b000;
    check("contention_count", 32'(k), 32'd4);
`ifdef SPI_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) check("contention_order", 32'(order[i]), 32'd0);
`else
    for (int i = 0; i < 4; i++) check("contention_order", 32'(order[i]), 32'(i % 3));
`endif
    wait_idle(20);

`ifdef SPI_ARBITER_FIXED_PRIO_EN
    // Requester 0 arrives mid-transfer and overtakes requester 2.
    pulse_reset();
    req = 3'b110;
    k = 0;
    while (!m_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req[0] = 1'b1;
    k = 0;
    for (int n = 0; n < 200 && k < 3; n++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        order[k] = done_index(done);
        req[order[k]] = 1'b0;
        k++;
      end
    end
    req = 3'b000;
    check("fixed_count", 32'(k), 32'd3);
    check("fixed_order_0", 32'(order[0]), 32'd1);
    check("fixed_order_1", 32'(order[1]), 32'd0);
    check("fixed_order_2", 32'(order[2]), 32'd2);
    wait_idle(20);
`endif

    // Random traffic: requesters come and go, data churns, occasional early release.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req_ss[2*i +: 2]   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end else if (gnt[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, 2);
        req_data[8*j +: 8] = 8'($urandom);
        req_ss[2*j +: 2]   = 2'($urandom_range(0, 3));
      end
      if (!busy) m_data_received = 8'($urandom);
    end
    req = 3'b000;
    wait_idle(60);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
